// File: rtl/scff_chain_loader.sv
// Configuration chain loader: serialises input words into the scff chain head
// and repacks the old chain contents leaving the tail into readback words.
module scff_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_data,
   output logic              sc_head,
   output logic              sc_en,
   input  logic              sc_tail,
   output logic              busy,
   output logic              done
);

   localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
   localparam int CW        = $clog2(WORD_W + 1);
   localparam int NW        = $clog2(NWORDS + 1);
   localparam int BW        = $clog2(CHAIN_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FLUSH} state_t;

   state_t            r_state, w_next;
   logic [WORD_W-1:0] r_buf, r_cap, r_m_data, w_cap_new;
   logic [CW-1:0]     r_in_cnt, r_cap_cnt;
   logic [NW-1:0]     r_words_in;
   logic [BW-1:0]     r_bit_cnt;
   logic              r_cap_full, r_m_valid, r_head, r_done;
   logic              w_m_free, w_out_block, w_shift, w_buf_bit, w_s_ready;
   logic              w_accept, w_last_bit, w_cap_last;

   always_comb begin
      w_m_free    = !r_m_valid || m_ready;
      w_out_block = r_cap_full && !w_m_free;
      w_shift     = (r_state == S_SHIFT) && (r_in_cnt != '0) && !w_out_block;
      w_buf_bit   = MSB_FIRST ? r_buf[WORD_W-1] : r_buf[0];
      w_s_ready   = (r_state == S_SHIFT) && (r_words_in < NW'(NWORDS)) &&
                    ((r_in_cnt == '0) || ((r_in_cnt == CW'(1)) && w_shift));
      w_accept    = s_valid && w_s_ready;
      w_last_bit  = (r_bit_cnt == BW'(CHAIN_LEN - 1));
      w_cap_last  = (r_cap_cnt == CW'(WORD_W - 1)) || w_last_bit;
      // A held (complete) word is always drained on any cycle that shifts,
      // so the new bit starts a fresh word.
      w_cap_new   = r_cap_full ? '0 : r_cap;
      for (int i = 0; i < WORD_W; i++) begin
         if (CW'(MSB_FIRST ? (WORD_W - 1 - i) : i) == r_cap_cnt)
            w_cap_new[i] = sc_tail;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_SHIFT;
         S_SHIFT: if (w_shift && w_last_bit) w_next = S_FLUSH;
         S_FLUSH: if (r_m_valid && m_ready && !r_cap_full) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_buf      <= '0;
         r_in_cnt   <= '0;
         r_words_in <= '0;
         r_bit_cnt  <= '0;
         r_cap      <= '0;
         r_cap_cnt  <= '0;
         r_cap_full <= 1'b0;
         r_m_valid  <= 1'b0;
         r_m_data   <= '0;
         r_head     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == S_FLUSH) && (w_next == S_IDLE);
         if (r_state == S_IDLE) begin
            if (start) begin
               r_buf      <= '0;
               r_in_cnt   <= '0;
               r_words_in <= '0;
               r_bit_cnt  <= '0;
               r_cap      <= '0;
               r_cap_cnt  <= '0;
               r_cap_full <= 1'b0;
            end
         end else begin
            if (w_accept) begin
               r_buf      <= s_data;
               r_in_cnt   <= (r_words_in == NW'(NWORDS - 1)) ? CW'(LAST_BITS) : CW'(WORD_W);
               r_words_in <= r_words_in + NW'(1);
            end else if (w_shift) begin
               r_buf    <= MSB_FIRST ? (r_buf << 1) : (r_buf >> 1);
               r_in_cnt <= r_in_cnt - CW'(1);
            end
            if (w_shift) begin
               r_bit_cnt <= r_bit_cnt + BW'(1);
               r_head    <= w_buf_bit;
            end

            // NOTE: later non-blocking assignments in this block override
            // earlier ones, so the capture path below wins over the drain path.
            if (r_m_valid && m_ready)
               r_m_valid <= 1'b0;
            if (r_cap_full && w_m_free) begin
               r_m_data   <= r_cap;
               r_m_valid  <= 1'b1;
               r_cap      <= '0;
               r_cap_full <= 1'b0;
            end
            if (w_shift) begin
               if (w_cap_last) begin
                  r_cap_cnt <= '0;
                  if (w_m_free && !r_cap_full) begin
                     r_m_data  <= w_cap_new;
                     r_m_valid <= 1'b1;
                     r_cap     <= '0;
                  end else begin
                     r_cap      <= w_cap_new;
                     r_cap_full <= 1'b1;
                  end
               end else begin
                  r_cap     <= w_cap_new;
                  r_cap_cnt <= r_cap_cnt + CW'(1);
               end
            end
         end
      end
   end

   assign s_ready = w_s_ready;
   assign sc_en   = w_shift;
   assign sc_head = w_shift ? w_buf_bit : r_head;
   assign m_valid = r_m_valid;
   assign m_data  = r_m_data;
   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;

endmodule

// File: tb/tb_scff_chain_loader.sv
// Directed bench for scff_chain_loader: a 20-cell LSB-first chain and an
// 8-cell MSB-first chain, each modelled as a plain shift register.
module tb_scff_chain_loader;

   localparam int CL = 20;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start, s_valid, s_ready, m_valid, m_ready, sc_head, sc_en, sc_tail, busy, done;
   logic [7:0] s_data, m_data;
   logic       start_b, s_valid_b, s_ready_b, m_valid_b, m_ready_b, sc_head_b, sc_en_b, sc_tail_b;
   logic       busy_b, done_b;
   logic [7:0] s_data_b, m_data_b;

   scff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(8), .MSB_FIRST(1'b0)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .sc_head(sc_head), .sc_en(sc_en), .sc_tail(sc_tail), .busy(busy), .done(done));

   scff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8), .MSB_FIRST(1'b1)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
      .s_data(s_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
      .sc_head(sc_head_b), .sc_en(sc_en_b), .sc_tail(sc_tail_b), .busy(busy_b), .done(done_b));

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic       clr = 1'b0;
   logic       do_preload = 1'b0;
   logic [7:0] words [0:3] = '{8'h5A, 8'h3C, 8'hF7, 8'h99};

   // fabric chain models; index 0 is the tail cell
   logic [CL-1:0] chain;
   logic [7:0]    chain_b, head_log, rb_b;
   logic [3:0]    en_b;
   int            done_b_n, acc_b;
   assign sc_tail   = chain[0];
   assign sc_tail_b = chain_b[0];

   int         cyc = 0;
   int         en_cnt, first_en, last_en, acc, rb_n, first_mv, last_hs, done_cyc, done_n, start_cyc;
   logic       extra_rdy;
   logic [7:0] rb [0:7];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (clr) begin
         en_cnt <= 0; first_en <= -1; last_en <= -1; acc <= 0; rb_n <= 0;
         first_mv <= -1; last_hs <= -1; done_cyc <= -1; done_n <= 0; extra_rdy <= 1'b0;
         for (int i = 0; i < 8; i++) rb[i] <= 8'h00;
         if (do_preload) begin
            chain   <= 20'hABCDE;
            chain_b <= 8'hC5;
         end
         en_b <= '0; head_log <= '0; rb_b <= '0; done_b_n <= 0; acc_b <= 0;
      end else begin
         if (sc_en) begin
            chain  <= {sc_head, chain[CL-1:1]};
            en_cnt <= en_cnt + 1;
            if (first_en < 0) first_en <= cyc;
            last_en <= cyc;
         end
         if (start && !busy) start_cyc <= cyc;
         if (s_valid && s_ready) acc <= acc + 1;
         if (acc == 3 && s_ready) extra_rdy <= 1'b1;
         if (m_valid && first_mv < 0) first_mv <= cyc;
         if (m_valid && m_ready) begin
            if (rb_n < 8) rb[rb_n] <= m_data;
            rb_n    <= rb_n + 1;
            last_hs <= cyc;
         end
         if (done) begin
            done_cyc <= cyc;
            done_n   <= done_n + 1;
         end
         if (sc_en_b) begin
            chain_b            <= {sc_head_b, chain_b[7:1]};
            head_log[en_b[2:0]] <= sc_head_b;
            en_b               <= en_b + 4'd1;
         end
         if (s_valid_b && s_ready_b) acc_b <= acc_b + 1;
         if (m_valid_b && m_ready_b) rb_b <= m_data_b;
         if (done_b) done_b_n <= done_b_n + 1;
      end
   end

   task automatic run_a(input int n_words, input int gap_len, input bit stall,
                        input bit preload_en, input int rst_after, input bit start_mid);
      int gap_cnt = 0;
      int stall_k = -1;
      @(negedge clk);
      clr = 1'b1; do_preload = preload_en; start = 1'b0; s_valid = 1'b0; m_ready = !stall;
      @(negedge clk);
      clr = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
         if (rst_after > 0 && en_cnt == rst_after) begin
            rst = 1'b1;
            #1;
            check("rst_mid_outputs", {s_ready, m_valid, m_data, sc_en, sc_head, busy, done}, '0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         start = start_mid && (c == 4);
         if (gap_len > 0 && gap_cnt < gap_len && acc == 1 && (gap_cnt > 0 || en_cnt == 7)) begin
            s_valid = 1'b0;
            gap_cnt++;
         end else if (acc < n_words) begin
            s_valid = 1'b1;
            s_data  = words[acc];
         end else begin
            s_valid = 1'b0;
         end
         if (stall) begin
            if (stall_k < 0 && m_valid) stall_k = 0;
            if (stall_k == 10) begin
               check("stall_shift_count", en_cnt, 16);
               check("stall_sc_en", sc_en, 0);
               check("stall_m_valid", m_valid, 1);
               check("stall_m_data", m_data, 8'hDE);
               m_ready = 1'b1;
            end
            if (stall_k == 11) check("stall_resume_sc_en", sc_en, 1);
            if (stall_k >= 0 && stall_k <= 11) stall_k++;
         end
         if (done_n > 0) break;
         @(negedge clk);
      end
      check("done_seen", done_n, 1);
      @(negedge clk);
      check("done_single_pulse", {done, busy}, 2'b00);
   endtask

   task automatic check_results(input string tag, input logic [CL-1:0] exp_chain,
                                input logic [23:0] exp_rb, input int exp_span);
      check({tag, "_sc_en_count"}, en_cnt, CL);
      check({tag, "_sc_en_span"}, last_en - first_en + 1, exp_span);
      check({tag, "_first_shift"}, first_en - start_cyc, 2);
      check({tag, "_chain"}, chain, exp_chain);
      check({tag, "_rb_count"}, rb_n, 3);
      check({tag, "_rb"}, {rb[2], rb[1], rb[0]}, exp_rb);
      check({tag, "_done_latency"}, done_cyc - last_hs, 1);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      start_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0; m_ready_b = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs", {s_ready, m_valid, m_data, sc_en, sc_head, busy, done}, '0);
      rst = 1'b0;

      run_a(3, 0, 1'b0, 1'b1, 0, 1'b0);
      check_results("nominal", 20'h73C5A, 24'h0ABCDE, CL);
      check("nominal_first_m_valid", first_mv - start_cyc, 10);

      run_a(3, 3, 1'b0, 1'b1, 0, 1'b0);
      check_results("gap", 20'h73C5A, 24'h0ABCDE, CL + 3);

      run_a(3, 0, 1'b1, 1'b1, 0, 1'b0);
      check_results("stall", 20'h73C5A, 24'h0ABCDE, CL + 2);

      run_a(4, 0, 1'b0, 1'b1, 0, 1'b1);
      check_results("extra_word", 20'h73C5A, 24'h0ABCDE, CL);
      check("extra_word_accepted", acc, 3);
      check("extra_word_s_ready", extra_rdy, 0);

      run_a(3, 0, 1'b0, 1'b1, 9, 1'b0);
      run_a(3, 0, 1'b0, 1'b0, 0, 1'b0);
      check_results("after_rst", 20'h73C5A, 24'h02D55E, CL);

      @(negedge clk);
      clr = 1'b1; do_preload = 1'b1;
      @(negedge clk);
      clr = 1'b0; start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0; s_valid_b = 1'b1; s_data_b = 8'h80; m_ready_b = 1'b1;
      for (int c = 0; c < 60; c++) begin
         if (acc_b > 0) s_valid_b = 1'b0;
         if (done_b_n > 0) break;
         @(negedge clk);
      end
      check("msb_done_seen", done_b_n, 1);
      check("msb_sc_en_count", en_b, 8);
      check("msb_head_bits", head_log, 8'h01);
      check("msb_rb_bit7", rb_b[7], 1);
      check("msb_rb", rb_b, 8'hA3);
      check("msb_chain", chain_b, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
